// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store data port onto one
// single-ported SRAM. One memory operation in flight at a time; reads return
// after RD_LAT cycles, stores complete in the command cycle.
module mem_port_arbiter #(
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_abort,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wmask,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_csb,
    output logic            mem_web,
    output logic [DW/8-1:0] mem_wmask,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout,
    output logic            busy
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_CNT = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IREAD = 2'd1,
        DREAD = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pref_d;   // 1: data port wins the next tie
    logic            r_abort;    // outstanding fetch has been abandoned

    logic            w_issue;
    logic            w_sel_d;
    logic            w_store;
    logic            w_read;
    logic            w_last;

    // Arbitration and command decode for the current cycle
    always_comb begin
        w_issue = (r_state == IDLE) && (i_req || d_req);
        w_sel_d = d_req && (!i_req || r_pref_d);
        w_store = w_issue && w_sel_d && d_we;
        w_read  = w_issue && !(w_sel_d && d_we);
        w_last  = (r_cnt == LAST_CNT);
    end

    // SRAM command, grants and read-return outputs
    always_comb begin
        i_gnt     = w_issue && !w_sel_d;
        d_gnt     = w_issue && w_sel_d;
        mem_csb   = !w_issue;
        mem_web   = !w_store;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_din   = '0;
        if (w_issue) begin
            mem_addr = w_sel_d ? d_addr : i_addr;
        end
        if (w_store) begin
            mem_wmask = d_wmask;
            mem_din   = d_wdata;
        end
        busy     = (r_state != IDLE);
        i_rvalid = (r_state == IREAD) && w_last && !r_abort && !i_abort;
        d_rvalid = (r_state == DREAD) && w_last;
        i_rdata  = i_rvalid ? mem_dout : '0;
        d_rdata  = d_rvalid ? mem_dout : '0;
    end

    // FSM: issue from IDLE, count read latency, track fetch abort and fairness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pref_d <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_pref_d <= !w_sel_d;
                    end
                    if (w_read) begin
                        r_state <= w_sel_d ? DREAD : IREAD;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                    end
                end
                default: begin
                    if ((r_state == IREAD) && i_abort) begin
                        r_abort <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // Byte-mask width is tied to DW; keep the relationship visible
    logic [MW-1:0] w_mask_width_ref;
    assign w_mask_width_ref = d_wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=2 and RD_LAT=15), each with
// its own SRAM model, checked every cycle against a timestamp-based model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic clk;
    logic rst;

    logic          i_req    [2];
    logic [AW-1:0] i_addr   [2];
    logic          i_abort  [2];
    logic          i_gnt    [2];
    logic          i_rvalid [2];
    logic [DW-1:0] i_rdata  [2];
    logic          d_req    [2];
    logic          d_we     [2];
    logic [AW-1:0] d_addr   [2];
    logic [DW-1:0] d_wdata  [2];
    logic [MW-1:0] d_wmask  [2];
    logic          d_gnt    [2];
    logic          d_rvalid [2];
    logic [DW-1:0] d_rdata  [2];
    logic          mem_csb  [2];
    logic          mem_web  [2];
    logic [MW-1:0] mem_wmask[2];
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_din  [2];
    logic [DW-1:0] mem_dout [2];
    logic          busy     [2];

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u0 (
        .clk(clk), .rst(rst),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_abort(i_abort[0]),
        .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_wmask(d_wmask[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_csb(mem_csb[0]), .mem_web(mem_web[0]), .mem_wmask(mem_wmask[0]),
        .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0]),
        .busy(busy[0])
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(15)) u1 (
        .clk(clk), .rst(rst),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_abort(i_abort[1]),
        .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_wmask(d_wmask[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_csb(mem_csb[1]), .mem_web(mem_web[1]), .mem_wmask(mem_wmask[1]),
        .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt;
    int n_fail;
    int cyc;

    // SRAM contents and in-flight read per instance
    logic [DW-1:0] mem [2][1024];
    int            sr_due  [2];
    logic [DW-1:0] sr_data [2];

    // Reference model state: a read is outstanding while cyc <= rv_cyc
    int            rv_cyc   [2];
    bit            own_d    [2];
    bit            abrt     [2];
    bit            pref_d   [2];
    logic [DW-1:0] exp_data [2];
    bit            g_i      [2];
    bit            g_d      [2];

    // Output snapshots taken at the checking edge
    logic          s_ig [2], s_dg [2], s_irv [2], s_drv [2], s_busy [2];
    logic          s_csb [2], s_web [2];
    logic [MW-1:0] s_wm [2];
    logic [AW-1:0] s_addr [2];
    logic [DW-1:0] s_din [2], s_ird [2], s_drd [2];

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, expv);
        end
    endtask

    task automatic model_check(input int k);
        int            lat;
        bit            win_d;
        logic          e_ig, e_dg, e_irv, e_drv, e_busy, e_csb, e_web;
        logic [MW-1:0] e_wm;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_ird, e_drd;
        lat = (k == 0) ? 2 : 15;
        e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_busy = 0; e_csb = 1; e_web = 1;
        e_wm = '0; e_addr = '0; e_din = '0; e_ird = '0; e_drd = '0;
        g_i[k] = 0; g_d[k] = 0;
        if (rst) begin
            rv_cyc[k] = -100; pref_d[k] = 0; abrt[k] = 0;
        end else if (cyc <= rv_cyc[k]) begin
            e_busy = 1;
            if (!own_d[k] && i_abort[k]) abrt[k] = 1;
            if (cyc == rv_cyc[k]) begin
                if (own_d[k]) begin
                    e_drv = 1; e_drd = exp_data[k];
                end else if (!abrt[k]) begin
                    e_irv = 1; e_ird = exp_data[k];
                end
            end
        end else if (i_req[k] || d_req[k]) begin
            win_d = d_req[k] && (!i_req[k] || pref_d[k]);
            pref_d[k] = !win_d;
            e_csb = 0;
            if (win_d) begin
                e_dg = 1; g_d[k] = 1; e_addr = d_addr[k];
                if (d_we[k]) begin
                    e_web = 0; e_wm = d_wmask[k]; e_din = d_wdata[k];
                end else begin
                    rv_cyc[k] = cyc + lat; own_d[k] = 1; abrt[k] = 0;
                    exp_data[k] = mem[k][d_addr[k]];
                end
            end else begin
                e_ig = 1; g_i[k] = 1; e_addr = i_addr[k];
                rv_cyc[k] = cyc + lat; own_d[k] = 0; abrt[k] = 0;
                exp_data[k] = mem[k][i_addr[k]];
            end
        end
        chk("i_gnt",     k, 64'(i_gnt[k]),     64'(e_ig));
        chk("d_gnt",     k, 64'(d_gnt[k]),     64'(e_dg));
        chk("i_rvalid",  k, 64'(i_rvalid[k]),  64'(e_irv));
        chk("d_rvalid",  k, 64'(d_rvalid[k]),  64'(e_drv));
        chk("i_rdata",   k, 64'(i_rdata[k]),   64'(e_ird));
        chk("d_rdata",   k, 64'(d_rdata[k]),   64'(e_drd));
        chk("busy",      k, 64'(busy[k]),      64'(e_busy));
        chk("mem_csb",   k, 64'(mem_csb[k]),   64'(e_csb));
        chk("mem_web",   k, 64'(mem_web[k]),   64'(e_web));
        chk("mem_wmask", k, 64'(mem_wmask[k]), 64'(e_wm));
        chk("mem_addr",  k, 64'(mem_addr[k]),  64'(e_addr));
        chk("mem_din",   k, 64'(mem_din[k]),   64'(e_din));
        s_ig[k] = i_gnt[k]; s_dg[k] = d_gnt[k]; s_irv[k] = i_rvalid[k]; s_drv[k] = d_rvalid[k];
        s_busy[k] = busy[k]; s_csb[k] = mem_csb[k]; s_web[k] = mem_web[k]; s_wm[k] = mem_wmask[k];
        s_addr[k] = mem_addr[k]; s_din[k] = mem_din[k]; s_ird[k] = i_rdata[k]; s_drd[k] = d_rdata[k];
    endtask

    // SRAM behaviour for the command seen in the cycle that just ended
    task automatic sram_update(input int k);
        int lat;
        lat = (k == 0) ? 2 : 15;
        if (!rst && !s_csb[k]) begin
            if (!s_web[k]) begin
                for (int b = 0; b < int'(MW); b++)
                    if (s_wm[k][b]) mem[k][s_addr[k]][b*8 +: 8] = s_din[k][b*8 +: 8];
            end else begin
                sr_due[k]  = cyc - 1 + lat;
                sr_data[k] = mem[k][s_addr[k]];
            end
        end
        mem_dout[k] = (cyc == sr_due[k]) ? sr_data[k] : $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) sram_update(k);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; d_req[k] = 0; i_abort[k] = 0; d_we[k] = 0;
        end
        for (int j = 0; j < n; j++) tick();
    endtask

    int t_grant;
    int n_wait;
    bit seen;

    initial begin
        n_asrt = 0; n_fail = 0; cyc = 0;
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; i_addr[k] = '0; i_abort[k] = 0;
            d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0; d_wmask[k] = '0;
            mem_dout[k] = $urandom;
            sr_due[k] = -100; sr_data[k] = '0;
            rv_cyc[k] = -100; own_d[k] = 0; abrt[k] = 0; pref_d[k] = 0;
            exp_data[k] = '0;
            for (int a = 0; a < 1024; a++) mem[k][a] = $urandom;
        end
        tick();
        tick();
        @(posedge clk); #1; cyc++;
        rst = 0;

        // Simultaneous requests after reset: I at T, D at T+3, I at T+6
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 1; i_addr[k] = 10'h040;
            d_req[k] = 1; d_we[k] = 0; d_addr[k] = 10'h080;
        end
        for (int j = 0; j < 9; j++) begin
            tick();
            if (j == 0) chk("s2_first_i", 0, 64'(s_ig[0]), 64'(1));
            if (j == 3) chk("s2_then_d",  0, 64'(s_dg[0]), 64'(1));
            if (j == 6) chk("s2_alt_i",   0, 64'(s_ig[0]), 64'(1));
        end
        idle(18);

        // Lone fetch returning 0xDEADBEEF
        mem[0][10'h010] = 32'hDEADBEEF;
        i_req[0] = 1; i_addr[0] = 10'h010;
        tick();
        chk("s1_gnt", 0, 64'(s_ig[0]), 64'(1));
        chk("s1_csb", 0, 64'(s_csb[0]), 64'(0));
        i_req[0] = 0;
        tick();
        chk("s1_busy1", 0, 64'(s_busy[0]), 64'(1));
        tick();
        chk("s1_rvalid", 0, 64'(s_irv[0]), 64'(1));
        chk("s1_rdata",  0, 64'(s_ird[0]), 64'(32'hDEADBEEF));
        chk("s1_busy2",  0, 64'(s_busy[0]), 64'(1));
        idle(4);

        // Store with a fetch pending
        d_req[0] = 1; d_we[0] = 1; d_addr[0] = 10'h3FF; d_wdata[0] = 32'h12345678; d_wmask[0] = 4'h3;
        i_req[0] = 1; i_addr[0] = 10'h020;
        tick();
        chk("s3_dgnt",  0, 64'(s_dg[0]),   64'(1));
        chk("s3_web",   0, 64'(s_web[0]),  64'(0));
        chk("s3_wmask", 0, 64'(s_wm[0]),   64'(4'h3));
        chk("s3_addr",  0, 64'(s_addr[0]), 64'(10'h3FF));
        chk("s3_din",   0, 64'(s_din[0]),  64'(32'h12345678));
        d_req[0] = 0; d_we[0] = 0;
        tick();
        chk("s3_next_i", 0, 64'(s_ig[0]),  64'(1));
        chk("s3_no_drv", 0, 64'(s_drv[0]), 64'(0));
        idle(4);

        // Aborted fetch
        i_req[0] = 1; i_addr[0] = 10'h030;
        tick();
        chk("s4_gnt", 0, 64'(s_ig[0]), 64'(1));
        i_abort[0] = 1; i_addr[0] = 10'h034;
        tick();
        i_abort[0] = 0;
        tick();
        chk("s4_no_rv", 0, 64'(s_irv[0]), 64'(0));
        tick();
        chk("s4_regnt", 0, 64'(s_ig[0]), 64'(1));
        idle(4);

        // Reset in the middle of a data read
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 10'h005;
        tick();
        chk("s5_gnt", 0, 64'(s_dg[0]), 64'(1));
        d_req[0] = 0;
        rst = 1;
        #1;
        chk("s5_csb",  0, 64'(mem_csb[0]),  64'(1));
        chk("s5_busy", 0, 64'(busy[0]),     64'(0));
        chk("s5_drv",  0, 64'(d_rvalid[0]), 64'(0));
        tick();
        tick();
        rst = 0;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 10'h006;
        tick();
        chk("s5_first", 0, 64'(s_dg[0]), 64'(1));
        idle(18);

        // Long latency on the RD_LAT=15 instance
        i_req[1] = 1; i_addr[1] = 10'h011;
        tick();
        chk("s6_gnt", 1, 64'(s_ig[1]), 64'(1));
        i_req[1] = 0;
        n_wait = 0; seen = 0;
        while (!seen && n_wait < 20) begin
            tick();
            n_wait++;
            if (s_irv[1]) seen = 1;
        end
        chk("s6_lat", 1, 64'(n_wait), 64'(15));
        idle(3);

        // Randomized traffic with held requests and random aborts
        t_grant = 0;
        for (int j = 0; j < 3000; j++) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_req[k] || g_i[k]) begin
                    i_req[k]  = ($urandom_range(0, 9) < 6);
                    i_addr[k] = 10'($urandom_range(0, 15));
                end
                if (!d_req[k] || g_d[k]) begin
                    d_req[k]   = ($urandom_range(0, 9) < 5);
                    d_we[k]    = ($urandom_range(0, 2) == 0);
                    d_addr[k]  = 10'($urandom_range(0, 15));
                    d_wdata[k] = $urandom;
                    d_wmask[k] = 4'($urandom_range(0, 15));
                end
                i_abort[k] = ($urandom_range(0, 9) == 0);
            end
            tick();
            if (g_i[0] || g_d[0]) t_grant++;
        end
        chk("rand_activity", 0, 64'(t_grant > 100), 64'(1));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
